// File: rtl/carry_lookahead_adder_pkg.sv
// Shared constants and helpers for the two-level carry-lookahead adder.
// cla_carry() is a flat sum-of-products carry over a span of generate/propagate pairs.
package carry_lookahead_adder_pkg;

   localparam int unsigned CLA_GROUP_W = 4;
   localparam int          CLA_SPAN_W  = 32;

   typedef logic [CLA_SPAN_W-1:0] cla_vec_t;

   function automatic int unsigned cla_num_groups(input int unsigned n);
      return (n + CLA_GROUP_W - 1) / CLA_GROUP_W;
   endfunction

   // Carry into position k of a span: OR over j<k of g[j] & p[j+1..k-1], plus cin & p[0..k-1].
   function automatic logic cla_carry(input cla_vec_t g, input cla_vec_t p, input logic cin,
                                      input int k);
      logic c;
      logic t;
      t = cin;
      for (int m = 0; m < CLA_SPAN_W; m++) begin
         if (m < k) t &= p[m];
      end
      c = t;
      for (int j = 0; j < CLA_SPAN_W; j++) begin
         if (j < k) begin
            t = g[j];
            for (int m = 0; m < CLA_SPAN_W; m++) begin
               if (m > j && m < k) t &= p[m];
            end
            c |= t;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/carry_lookahead_adder_cla_group4.sv
// 4-bit lookahead group: flat sum-of-products internal carries, exports group P and G.
module cla_group4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       p_o,
   output logic       g_o
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   assign c[0] = cin_i;
   assign c[1] = g[0] | (p[0] & cin_i);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);

   assign sum_o = p ^ c;
   assign p_o   = &p;
   assign g_o   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/carry_lookahead_adder.sv
// N-bit unsigned carry-lookahead adder with a registered (N+1)-bit sum.
// Groups of 4 bits, then block-of-4-groups lookahead with flat carries across blocks.
module carry_lookahead_adder
   import carry_lookahead_adder_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [N-1:0] num1,
   input  logic [N-1:0] num2,
   output logic         out_valid,
   output logic [N:0]   result
);

   localparam int unsigned NumGroups = cla_num_groups(N);
   localparam int unsigned NumBlocks = (NumGroups + 3) / 4;
   localparam int unsigned PadW      = NumGroups * CLA_GROUP_W;

   logic [PadW-1:0]        a_pad;
   logic [PadW-1:0]        b_pad;
   logic [PadW-1:0]        s_pad;
   logic [PadW:0]          sum_full;
   logic [N:0]             sum;
   logic [NumGroups-1:0]   grp_p;
   logic [NumGroups-1:0]   grp_g;
   logic [NumGroups:0]     c_grp;
   logic [NumBlocks*4-1:0] grp_p_pad;
   logic [NumBlocks*4-1:0] grp_g_pad;
   logic [NumBlocks-1:0]   blk_p;
   logic [NumBlocks-1:0]   blk_g;
   logic [NumBlocks-1:0]   blk_cin;
   logic [N:0]             result_d;
   logic [N:0]             result_q;
   logic                   valid_q;

   assign a_pad = PadW'(num1);
   assign b_pad = PadW'(num2);

   for (genvar gi = 0; gi < NumGroups; gi++) begin : gen_grp
      cla_group4 u_grp (
         .a_i   (a_pad[4*gi +: 4]),
         .b_i   (b_pad[4*gi +: 4]),
         .cin_i (c_grp[gi]),
         .sum_o (s_pad[4*gi +: 4]),
         .p_o   (grp_p[gi]),
         .g_o   (grp_g[gi])
      );
   end

   always_comb begin
      grp_p_pad                = '0;
      grp_g_pad                = '0;
      grp_p_pad[NumGroups-1:0] = grp_p;
      grp_g_pad[NumGroups-1:0] = grp_g;
   end

   always_comb begin
      blk_p = '0;
      blk_g = '0;
      for (int b = 0; b < int'(NumBlocks); b++) begin
         blk_p[b] = &grp_p_pad[4*b +: 4];
         blk_g[b] = cla_carry(cla_vec_t'(grp_g_pad[4*b +: 4]), cla_vec_t'(grp_p_pad[4*b +: 4]),
                              1'b0, 4);
      end
   end

   always_comb begin
      blk_cin = '0;
      for (int b = 0; b < int'(NumBlocks); b++) begin
         blk_cin[b] = cla_carry(cla_vec_t'(blk_g), cla_vec_t'(blk_p), 1'b0, b);
      end
   end

   // Each group carry is a flat function of its block's P/G and the block carry-in.
   always_comb begin
      c_grp = '0;
      for (int k = 1; k <= int'(NumGroups); k++) begin
         c_grp[k] = cla_carry(cla_vec_t'(grp_g_pad[4*((k-1)/4) +: 4]),
                              cla_vec_t'(grp_p_pad[4*((k-1)/4) +: 4]),
                              blk_cin[(k-1)/4], k - 4*((k-1)/4));
      end
   end

   // Padding bits have p = g = 0, so every bit above N is zero and the OR yields c[N].
   assign sum_full = {c_grp[NumGroups], s_pad};
   assign sum      = {|sum_full[PadW:N], sum_full[N-1:0]};

   always_comb begin
      result_d = in_valid ? sum : result_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         valid_q  <= in_valid;
      end
   end

   assign result    = result_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Self-checking bench: directed N=8 vector table, hold/reset sequences, and a random
// sweep over N in {1,5,8,16,32} against plain integer addition.
module tb_carry_lookahead_adder;

   logic clk = 1'b0;
   logic rst_n;

   logic        v8, ov8;
   logic [7:0]  a8, b8;
   logic [8:0]  r8;

   logic        vs, ov1, ov5, ov16, ov32;
   logic [0:0]  a1, b1;
   logic [1:0]  r1;
   logic [4:0]  a5, b5;
   logic [5:0]  r5;
   logic [15:0] a16, b16;
   logic [16:0] r16;
   logic [31:0] a32, b32;
   logic [32:0] r32;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[15];

   logic [63:0] ra, rb;
   logic [63:0] e1, e5, e8, e16, e32;

   always #5 clk = ~clk;

   carry_lookahead_adder #(.N(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .num1(a8), .num2(b8),
      .out_valid(ov8), .result(r8));
   carry_lookahead_adder #(.N(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(vs), .num1(a1), .num2(b1),
      .out_valid(ov1), .result(r1));
   carry_lookahead_adder #(.N(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .in_valid(vs), .num1(a5), .num2(b5),
      .out_valid(ov5), .result(r5));
   carry_lookahead_adder #(.N(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(vs), .num1(a16), .num2(b16),
      .out_valid(ov16), .result(r16));
   carry_lookahead_adder #(.N(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(vs), .num1(a32), .num2(b32),
      .out_valid(ov32), .result(r32));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   initial begin
      vecs[0]  = '{8'h00, 8'h00, 9'h000};
      vecs[1]  = '{8'hFF, 8'h00, 9'h0FF};
      vecs[2]  = '{8'h00, 8'hFF, 9'h0FF};
      vecs[3]  = '{8'hFF, 8'hFF, 9'h1FE};
      vecs[4]  = '{8'h0F, 8'hF0, 9'h0FF};
      vecs[5]  = '{8'h0F, 8'h0F, 9'h01E};
      vecs[6]  = '{8'hF0, 8'hF0, 9'h1E0};
      vecs[7]  = '{8'h7E, 8'h81, 9'h0FF};
      vecs[8]  = '{8'h63, 8'h82, 9'h0E5};
      vecs[9]  = '{8'h37, 8'h43, 9'h07A};
      vecs[10] = '{8'hC4, 8'h03, 9'h0C7};
      vecs[11] = '{8'h02, 8'hD1, 9'h0D3};
      vecs[12] = '{8'h7C, 8'h45, 9'h0C1};
      vecs[13] = '{8'h38, 8'h0F, 9'h047};
      vecs[14] = '{8'hFC, 8'h3C, 9'h138};

      rst_n = 1'b0;
      v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      vs = 1'b0; a1 = '0; b1 = '0; a5 = '0; b5 = '0;
      a16 = '0; b16 = '0; a32 = '0; b32 = '0;

      // Reset holds outputs at zero despite valid operands and clock edges.
      repeat (2) @(posedge clk);
      #1;
      check("reset_result", 64'(r8), 64'h000);
      check("reset_valid", 64'(ov8), 64'd0);

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_result", 64'(r8), 64'h1FE);
      check("post_reset_valid", 64'(ov8), 64'd1);

      // Back-to-back table: each result appears after the edge following its operands.
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         v8 = 1'b1; a8 = vecs[i].a; b8 = vecs[i].b;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_result", i), 64'(r8), 64'(vecs[i].exp));
         check($sformatf("vec%0d_valid", i), 64'(ov8), 64'd1);
      end

      // Hold: dropping in_valid clears out_valid but keeps the last sum.
      @(negedge clk);
      v8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
      @(posedge clk);
      #1;
      check("hold_valid", 64'(ov8), 64'd0);
      check("hold_result", 64'(r8), 64'h138);
      @(posedge clk);
      #1;
      check("hold_result2", 64'(r8), 64'h138);

      @(negedge clk);
      v8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
      @(posedge clk);
      #1;
      check("resume_result", 64'(r8), 64'h033);

      // Asynchronous mid-stream reset discards the pending sum.
      @(negedge clk);
      a8 = 8'h44; b8 = 8'h55;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_clear_result", 64'(r8), 64'h000);
      check("async_clear_valid", 64'(ov8), 64'd0);
      @(posedge clk);
      #1;
      check("reset_held_result", 64'(r8), 64'h000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_after_reset_result", 64'(r8), 64'h099);
      check("first_after_reset_valid", 64'(ov8), 64'd1);

      // Random sweep over widths; final iteration is all-ones + 1.
      for (int i = 0; i <= 1000; i++) begin
         @(negedge clk);
         if (i == 1000) begin
            ra = '1;
            rb = 64'd1;
         end else begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
         end
         vs = 1'b1; v8 = 1'b1;
         a1 = ra[0:0];   b1 = rb[0:0];
         a5 = ra[4:0];   b5 = rb[4:0];
         a8 = ra[7:0];   b8 = rb[7:0];
         a16 = ra[15:0]; b16 = rb[15:0];
         a32 = ra[31:0]; b32 = rb[31:0];
         e1  = 64'(a1) + 64'(b1);
         e5  = 64'(a5) + 64'(b5);
         e8  = 64'(a8) + 64'(b8);
         e16 = 64'(a16) + 64'(b16);
         e32 = 64'(a32) + 64'(b32);
         @(posedge clk);
         #1;
         check("rand_n1", 64'(r1), e1);
         check("rand_n5", 64'(r5), e5);
         check("rand_n8", 64'(r8), e8);
         check("rand_n16", 64'(r16), e16);
         check("rand_n32", 64'(r32), e32);
      end
      check("sweep_valid", 64'({ov1, ov5, ov8, ov16, ov32}), 64'h1F);
      check("n5_allones_plus1", 64'(r5), 64'h20);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
